// File: rtl/fp64_mul_sched.sv
// Round-robin scheduler sharing one combinational fp64 multiplier between NREQ
// requesters; operands are registered and held LAT cycles (multicycle path).

module fp64_mul (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    logic [10:0] ea, eb, ey;
    logic        za, zb;
    logic [53:0] prod_hi;
    logic [51:0] mant;

    assign ea = a[62:52];
    assign eb = b[62:52];
    // Denormal, Inf and NaN operands collapse to a +0 result.
    assign za = (ea == 11'd0) || (ea == 11'h7FF);
    assign zb = (eb == 11'd0) || (eb == 11'h7FF);
    assign prod_hi = 54'((106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]})) >> 52);
    assign mant = prod_hi[53] ? prod_hi[52:1] : prod_hi[51:0];
    assign ey = ea + eb - 11'd1023 + {10'd0, prod_hi[53]};
    assign y = (za || zb) ? 64'd0 : {a[63] ^ b[63], ey, mant};
endmodule

// state | meaning
// IDLE  | waiting for a request; combinational round-robin grant
// EXEC  | operands held in opa/opb, cnt counts down the multicycle budget
// RESP  | result held on rsp_y until the owning requester takes it
module fp64_mul_sched #(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [63:0]          rsp_y,
    input  logic                 flush,
    output logic                 busy
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [IW-1:0]    rr_ptr, tag;
    logic [1:0]       cnt;
    logic [63:0]      opa, opb, res, product;
    logic [2*NREQ-1:0] rot;
    logic             found;
    int               gnt_idx;
    logic [64*NREQ-1:0] a_sh, b_sh;

    fp64_mul u_mul (.a(opa), .b(opb), .y(product));

    // Rotate the valid vector so bit 0 is the requester at rr_ptr.
    always_comb begin
        rot = {req_valid, req_valid} >> rr_ptr;
        found = 1'b0;
        gnt_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                gnt_idx = (int'(rr_ptr) + k) % NREQ;
            end
        end
    end

    assign req_ready = (state == IDLE && !flush && found) ? (NREQ'(1) << gnt_idx) : '0;
    assign a_sh = req_a >> (64 * gnt_idx);
    assign b_sh = req_b >> (64 * gnt_idx);
    assign rsp_y = (state == RESP) ? res : 64'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            tag       <= '0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            rsp_valid <= '0;
            busy      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            rsp_valid <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        opa    <= a_sh[63:0];
                        opb    <= b_sh[63:0];
                        tag    <= IW'(gnt_idx);
                        rr_ptr <= IW'((gnt_idx + 1) % NREQ);
                        cnt    <= 2'(LAT - 1);
                        state  <= EXEC;
                        busy   <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == 2'd0) begin
                        res       <= product;
                        rsp_valid <= NREQ'(1) << tag;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (|(rsp_ready & rsp_valid)) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
